// File: rtl/tron_mem_pkg.sv
// tron_mem_pkg: definitions shared by the memory port-2 arbiter.
// Provides the default address/data widths, the wait-counter width,
// the requester-id encoding used by the read-return tag, and the
// arbiter FSM state encoding.
package tron_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 8;

  typedef enum logic {
    REQ_VID = 1'b0,
    REQ_LDR = 1'b1
  } req_id_e;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of consecutive cycles the loader
// has been kept waiting, with a compare against the starvation limit.
// Ports:
//   clk, reset    system clock, async active-high reset
//   wait_i        loader requesting and not granted this cycle
//   limit_hit_o   the count being loaded this cycle has reached the limit
module arb_starve_counter
  import tron_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_i,
  output logic limit_hit_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (wait_i) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Compare the next count so the FSM enters FORCE on the same edge the
  // count reaches the limit; the loader is then granted in the following
  // cycle, i.e. after exactly STARVE_LIMIT denied cycles.
  assign limit_hit_o = (cnt_d >= LIMIT_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares port 2 of the dual-port execution memory
// between the VGA pixel fetcher (read-only, priority) and the program
// loader/debug host (read/write). One access per cycle, grant decided
// combinationally in the request cycle, read data returned one cycle
// after the grant. A starvation counter forces the loader ahead of video
// after STARVE_LIMIT consecutive denied cycles.
// Ports:
//   clk, reset                         clock, async active-high reset
//   vid_req/vid_addr                   video read request
//   vid_gnt/vid_rvalid/vid_rdata       video grant and read return
//   ldr_req/ldr_we/ldr_addr/ldr_wdata  loader request
//   ldr_gnt/ldr_rvalid/ldr_rdata       loader grant and read return
//   mem_addr/mem_din/mem_we/mem_dout   memory port 2
//
// state  | meaning
// NORMAL | video has priority, loader served when video idle
// FORCE  | loader starved; loader has priority for one grant
module mem_port_arbiter
  import tron_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  arb_state_e state_q, state_d;
  logic       rd_pend_q, rd_pend_d;
  req_id_e    rd_who_q, rd_who_d;
  logic       limit_hit;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk         (clk),
    .reset       (reset),
    .wait_i      (ldr_req && !ldr_gnt),
    .limit_hit_o (limit_hit)
  );

  // Grants are masked during reset so nothing reaches the memory while
  // the block is held.
  always_comb begin
    vid_gnt = 1'b0;
    ldr_gnt = 1'b0;
    state_d = NORMAL;
    if (!reset) begin
      case (state_q)
        FORCE: begin
          if (ldr_req) ldr_gnt = 1'b1;
          else         vid_gnt = vid_req;
          // Either the loader got its grant or it withdrew.
          state_d = NORMAL;
        end
        default: begin
          if (vid_req) vid_gnt = 1'b1;
          else         ldr_gnt = ldr_req;
          state_d = limit_hit ? FORCE : NORMAL;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (vid_gnt) begin
      mem_addr = vid_addr;
    end else if (ldr_gnt) begin
      mem_addr = ldr_addr;
      mem_din  = ldr_wdata;
      mem_we   = ldr_we;
    end
  end

  always_comb begin
    rd_pend_d = vid_gnt || (ldr_gnt && !ldr_we);
    rd_who_d  = ldr_gnt ? REQ_LDR : REQ_VID;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= NORMAL;
      rd_pend_q <= 1'b0;
      rd_who_q  <= REQ_VID;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      rd_who_q  <= rd_who_d;
    end
  end

  assign vid_rvalid = rd_pend_q && (rd_who_q == REQ_VID);
  assign ldr_rvalid = rd_pend_q && (rd_who_q == REQ_LDR);
  assign vid_rdata  = mem_dout;
  assign ldr_rdata  = mem_dout;

endmodule
